ahb_sram_bridge: RTL and testbench

AHB-Lite slave that converts CPU bus transfers into the simple request/ready bus (`TB_*`) driven into the bench SRAM model. It sits between the Cortex-M4 system bus inside `top` and the `sram` instance. It performs byte-lane generation, wait-state insertion from `TB_READY`, AHB two-cycle ERROR responses, and optional posted-write buffering.

---
 rtl/ahb_sram_bridge_if.sv | 44 ++++
 rtl/ahb_sram_bridge.sv | 219 +++++++++++++++++++++
 tb/tb_ahb_sram_bridge.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_bridge_if.sv
// AHB-Lite slave signals plus the SRAM request/ready bus seen by the bridge.
// Latency: none, this is wiring only.
// Backpressure: HREADYOUT toward the CPU, TB_READY from the SRAM.
interface ahb_sram_bridge_if;
    // AHB-Lite slave side
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    // SRAM request/response side
    logic [31:0] TB_ADDRESS;
    logic [3:0]  TB_BL;
    logic        TB_WE;
    logic        TB_CE;
    logic [31:0] TB_WDATA;
    logic [1:0]  TB_TRANS;
    logic [31:0] TB_RDATA;
    logic [1:0]  TB_RESP;
    logic        TB_READY;
    // Sticky posted-write error
    logic        WBUF_ERR;

    // Bridge view
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  TB_RDATA, TB_RESP, TB_READY,
        output HREADYOUT, HRESP, HRDATA,
        output TB_ADDRESS, TB_BL, TB_WE, TB_CE, TB_WDATA, TB_TRANS, WBUF_ERR
    );

    // CPU + SRAM view
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output TB_RDATA, TB_RESP, TB_READY,
        input  HREADYOUT, HRESP, HRDATA,
        input  TB_ADDRESS, TB_BL, TB_WE, TB_CE, TB_WDATA, TB_TRANS, WBUF_ERR
    );
endinterface

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite to SRAM request/ready bridge: byte lanes, wait states, two-cycle ERROR.
// Latency: read HREADYOUT at N+2, write at N+3 (N+1 posted with AHB_SRAM_BRIDGE_WBUF_EN), +1 per SRAM wait.
// Backpressure: HREADYOUT held low until TB_READY; with the buffer full, new transfers stall until it drains.
module ahb_sram_bridge #(
    parameter int ADDR_BITS = 22
) (
    input  logic HCLK,
    input  logic HRESETn,
    ahb_sram_bridge_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_REQ, S_DONE, S_ERR1, S_ERR2, S_WPOST, S_WAITD
    } state_t;

    state_t      state;
    logic        hready_out;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] tb_address;
    logic [31:0] tb_wdata;
    logic [3:0]  tb_bl;
    logic        tb_we;
    logic        tb_ce;
    logic [1:0]  tb_trans;

    logic        accept;
    logic        misaligned;
    logic [3:0]  lanes;
    logic [31:0] addr_in;
    logic        unused;

`ifdef AHB_SRAM_BRIDGE_WBUF_EN
    // One-entry posted-write buffer lives in the tb_* request registers;
    // hold_* park a transfer that arrived while the buffer was still busy.
    logic        buf_vld;
    logic        wbuf_err;
    logic        busy;
    logic [31:0] hold_addr;
    logic [3:0]  hold_bl;
    logic        hold_write;
    logic [1:0]  hold_trans;

    // WPOST fills the buffer at the end of this cycle, so it counts as busy too
    assign busy = buf_vld | (state == S_WPOST);
    assign bus.WBUF_ERR = wbuf_err;
`else
    assign bus.WBUF_ERR = 1'b0;
`endif

    // Only the SRAM window bits of HADDR reach the SRAM
    assign unused = &{1'b0, bus.HADDR[31:ADDR_BITS]};

    // Address-phase decode: acceptance, alignment and little-endian byte lanes
    always_comb begin
        accept     = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
        misaligned = (bus.HSIZE > 3'd2)
                   | ((bus.HSIZE == 3'd1) & bus.HADDR[0])
                   | ((bus.HSIZE == 3'd2) & (bus.HADDR[1:0] != 2'b00));
        lanes = 4'b1111;
        case (bus.HSIZE)
            3'd0:    lanes = 4'b0001 << bus.HADDR[1:0];
            3'd1:    lanes = 4'b0011 << {bus.HADDR[1], 1'b0};
            default: lanes = 4'b1111;
        endcase
        addr_in = {{(32 - ADDR_BITS){1'b0}}, bus.HADDR[ADDR_BITS-1:0]};
    end

    // Bridge state machine; every output is a register updated on transitions
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= S_IDLE;
            hready_out <= 1'b1;
            hresp      <= 1'b0;
            hrdata     <= '0;
            tb_address <= '0;
            tb_wdata   <= '0;
            tb_bl      <= '0;
            tb_we      <= 1'b0;
            tb_ce      <= 1'b0;
            tb_trans   <= '0;
`ifdef AHB_SRAM_BRIDGE_WBUF_EN
            buf_vld    <= 1'b0;
            wbuf_err   <= 1'b0;
            hold_addr  <= '0;
            hold_bl    <= '0;
            hold_write <= 1'b0;
            hold_trans <= '0;
`endif
        end else begin
`ifdef AHB_SRAM_BRIDGE_WBUF_EN
            // Drain completion runs alongside the AHB side; errors are only flagged
            if (buf_vld && bus.TB_READY) begin
                tb_ce   <= 1'b0;
                buf_vld <= 1'b0;
                if (bus.TB_RESP == 2'b01)
                    wbuf_err <= 1'b1;
            end
`endif
            case (state)
`ifdef AHB_SRAM_BRIDGE_WBUF_EN
                S_IDLE, S_DONE, S_WPOST: begin
                    if (state == S_WPOST) begin
                        tb_wdata <= bus.HWDATA;
                        tb_ce    <= 1'b1;
                        buf_vld  <= 1'b1;
                    end
`else
                S_IDLE, S_DONE: begin
`endif
                    if (accept && misaligned) begin
                        state      <= S_ERR1;
                        hready_out <= 1'b0;
                        hresp      <= 1'b1;
`ifdef AHB_SRAM_BRIDGE_WBUF_EN
                    end else if (accept && busy) begin
                        hold_addr  <= addr_in;
                        hold_bl    <= lanes;
                        hold_write <= bus.HWRITE;
                        hold_trans <= bus.HTRANS;
                        state      <= S_WAITD;
                        hready_out <= 1'b0;
                        hresp      <= 1'b0;
`endif
                    end else if (accept) begin
                        tb_address <= addr_in;
                        tb_bl      <= lanes;
                        tb_we      <= bus.HWRITE;
                        tb_trans   <= bus.HTRANS;
                        hresp      <= 1'b0;
                        if (bus.HWRITE) begin
`ifdef AHB_SRAM_BRIDGE_WBUF_EN
                            state      <= S_WPOST;
                            hready_out <= 1'b1;
`else
                            state      <= S_WDATA;
                            hready_out <= 1'b0;
`endif
                        end else begin
                            state      <= S_REQ;
                            tb_ce      <= 1'b1;
                            hready_out <= 1'b0;
                        end
                    end else begin
                        state      <= S_IDLE;
                        hready_out <= 1'b1;
                        hresp      <= 1'b0;
                    end
                end
                S_WDATA: begin
                    tb_wdata <= bus.HWDATA;
                    tb_ce    <= 1'b1;
                    state    <= S_REQ;
                end
                S_REQ: begin
                    if (bus.TB_READY) begin
                        tb_ce <= 1'b0;
                        if (bus.TB_RESP == 2'b01) begin
                            state      <= S_ERR1;
                            hready_out <= 1'b0;
                            hresp      <= 1'b1;
                        end else begin
                            if (!tb_we)
                                hrdata <= bus.TB_RDATA;
                            state      <= S_DONE;
                            hready_out <= 1'b1;
                            hresp      <= 1'b0;
                        end
                    end
                end
                S_ERR1: begin
                    state      <= S_ERR2;
                    hready_out <= 1'b1;
                    hresp      <= 1'b1;
                end
                S_ERR2: begin
                    // A transfer offered during ERR2 is dropped; the master may cancel
                    state      <= S_IDLE;
                    hready_out <= 1'b1;
                    hresp      <= 1'b0;
                end
`ifdef AHB_SRAM_BRIDGE_WBUF_EN
                S_WAITD: begin
                    // Issue only once CE has been low for a cycle after the drain
                    if (!buf_vld) begin
                        tb_address <= hold_addr;
                        tb_bl      <= hold_bl;
                        tb_we      <= hold_write;
                        tb_trans   <= hold_trans;
                        if (hold_write) begin
                            state      <= S_WPOST;
                            hready_out <= 1'b1;
                        end else begin
                            state <= S_REQ;
                            tb_ce <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state      <= S_IDLE;
                    hready_out <= 1'b1;
                    hresp      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HREADYOUT  = hready_out;
    assign bus.HRESP      = hresp;
    assign bus.HRDATA     = hrdata;
    assign bus.TB_ADDRESS = tb_address;
    assign bus.TB_BL      = tb_bl;
    assign bus.TB_WE      = tb_we;
    assign bus.TB_CE      = tb_ce;
    assign bus.TB_WDATA   = tb_wdata;
    assign bus.TB_TRANS   = tb_trans;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Bench for ahb_sram_bridge: directed spec scenarios plus randomized transfers
// checked against a byte-addressed reference memory and a word-array SRAM model.
// Define AHB_SRAM_BRIDGE_WBUF_EN for both bench and RTL to exercise posted writes.
module tb_ahb_sram_bridge;

    logic HCLK;
    logic HRESETn;

    ahb_sram_bridge_if bus();

    ahb_sram_bridge #(.ADDR_BITS(22)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    // Single-slave system: the bus HREADY is this slave's HREADYOUT
    assign bus.HREADY = bus.HREADYOUT;

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  ref_mem  [0:1023];
    logic [31:0] sram_mem [0:255];
    int          sram_wait = 0;
    int          err_req   = 0;
    int          err_used  = 0;
    int          sram_cnt  = 0;
    int          acc_cnt   = 0;
    logic [31:0] last_addr = '0;
    logic [3:0]  last_bl   = '0;
    logic        last_we   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // SRAM model: sram_wait low cycles per request, then one READY cycle
    initial begin
        bus.TB_READY = 1'b0;
        bus.TB_RESP  = 2'b00;
        bus.TB_RDATA = '0;
        forever begin
            @(negedge HCLK);
            if (bus.TB_CE === 1'b1) begin
                if (sram_cnt >= sram_wait) begin
                    bus.TB_READY = 1'b1;
                    bus.TB_RESP  = (err_req != err_used) ? 2'b01 : 2'b00;
                    if (err_req == err_used) begin
                        if (bus.TB_WE) begin
                            for (int b = 0; b < 4; b++)
                                if (bus.TB_BL[b])
                                    sram_mem[bus.TB_ADDRESS[9:2]][8*b +: 8] = bus.TB_WDATA[8*b +: 8];
                        end else begin
                            bus.TB_RDATA = sram_mem[bus.TB_ADDRESS[9:2]];
                        end
                    end else begin
                        err_used++;
                    end
                    last_addr = bus.TB_ADDRESS;
                    last_bl   = bus.TB_BL;
                    last_we   = bus.TB_WE;
                    acc_cnt++;
                    sram_cnt  = 0;
                end else begin
                    bus.TB_READY = 1'b0;
                    sram_cnt++;
                end
            end else begin
                bus.TB_READY = 1'b0;
                bus.TB_RESP  = 2'b00;
                sram_cnt     = 0;
            end
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'(a & 32'h3FC);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [2:0] size, input logic [31:0] d);
        int n, off, base;
        n    = 1 << size;
        off  = int'(a & 32'h3);
        base = int'(a & 32'h3FF);
        for (int i = 0; i < n; i++)
            ref_mem[base + i] = d[8*(off + i) +: 8];
    endtask

    // One non-pipelined AHB transfer; lat = cycles after the address phase until HREADYOUT=1
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wd, output logic [31:0] rd, output int lat,
                        output bit err, output bit err1, output int ce_cyc, output bit moved);
        logic [31:0] a0;
        bit first;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr;
        bus.HWRITE = wr; bus.HSIZE = size;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = wd;
        lat = 1; err = 0; err1 = 0; ce_cyc = 0; moved = 0; first = 1; rd = '0; a0 = '0;
        while (1) begin
            @(negedge HCLK);
            if (bus.TB_CE === 1'b1) begin
                if (first) a0 = bus.TB_ADDRESS;
                else if (bus.TB_ADDRESS !== a0) moved = 1;
                first = 0;
                ce_cyc++;
            end
            if (bus.HREADYOUT === 1'b1) begin
                err = bus.HRESP;
                rd  = bus.HRDATA;
                break;
            end
            if (bus.HRESP === 1'b1) err1 = 1;
            if (lat >= 60) begin
                chk("xfer_timeout", {31'd0, bus.HREADYOUT}, 32'd1);
                break;
            end
            lat++;
            @(posedge HCLK); #1;
        end
    endtask

    // Transfer plus full check against the reference model
    task automatic op(input string tag, input bit wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] r;
        int lat, cec, c0, tmp;
        bit e, e1, mv, mis;
        logic [3:0] ebl;
        mis = (size > 3'd2) || ((addr % (32'd1 << size)) != 0);
        tmp = ((1 << (1 << size)) - 1) << (addr & 32'h3);
        ebl = tmp[3:0];
        c0  = acc_cnt;
        xfer(wr, addr, size, wd, r, lat, e, e1, cec, mv);
        if (wr) repeat (6) @(posedge HCLK);
        if (mis) begin
            chk({tag, "_err"},   {31'd0, e},  32'd1);
            chk({tag, "_err1"},  {31'd0, e1}, 32'd1);
            chk({tag, "_lat"},   lat,         32'd2);
            chk({tag, "_noreq"}, acc_cnt - c0, 32'd0);
        end else begin
            chk({tag, "_resp"}, {31'd0, e}, 32'd0);
            chk({tag, "_nreq"}, acc_cnt - c0, 32'd1);
            chk({tag, "_bl"},   {28'd0, last_bl}, {28'd0, ebl});
            chk({tag, "_addr"}, last_addr, addr & 32'h003F_FFFF);
            chk({tag, "_we"},   {31'd0, last_we}, {31'd0, wr});
            if (wr) begin
`ifdef AHB_SRAM_BRIDGE_WBUF_EN
                chk({tag, "_wlat"}, lat, 32'd1);
`else
                chk({tag, "_wlat"}, lat, 32'd3 + sram_wait);
`endif
                ref_write(addr, size, wd);
            end else begin
                chk({tag, "_rlat"}, lat, 32'd2 + sram_wait);
                chk({tag, "_data"}, r, ref_word(addr));
            end
        end
        rd = r;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tbctl"}, {24'd0, bus.TB_CE, bus.TB_WE, bus.TB_BL, bus.TB_TRANS}, 32'd0);
        chk({tag, "_tbaddr"}, bus.TB_ADDRESS, 32'd0);
        chk({tag, "_tbwdata"}, bus.TB_WDATA, 32'd0);
        chk({tag, "_hrdata"}, bus.HRDATA, 32'd0);
        chk({tag, "_hflags"}, {29'd0, bus.HREADYOUT, bus.HRESP, bus.WBUF_ERR}, 32'b100);
    endtask

    initial begin
        logic [31:0] r;
        int lat, cec;
        bit e, e1, mv;
        bit wr;
        logic [2:0] sz;
        logic [31:0] a;

        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        for (int i = 0; i < 256; i++) sram_mem[i] = '0;
        bus.HSEL = 0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 0;
        bus.HSIZE = 3'd0; bus.HWDATA = '0;
        HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1 check_reset("por");
        @(negedge HCLK) HRESETn = 1'b1;

        // Byte and halfword lanes on zeroed memory
        op("lane_b", 1, 32'h103, 3'd0, 32'hAA00_0000, r);
        op("lane_h", 1, 32'h100, 3'd1, 32'h0000_1234, r);
        op("lane_rd", 0, 32'h100, 3'd2, 32'h0, r);
        chk("lane_val", r, 32'hAA00_1234);

        // Word write/read
        op("word_wr", 1, 32'h100, 3'd2, 32'hDEAD_BEEF, r);
        op("word_rd", 0, 32'h100, 3'd2, 32'h0, r);
        chk("word_val", r, 32'hDEAD_BEEF);

        // Three SRAM wait states on a read
        sram_wait = 3;
        xfer(0, 32'h100, 3'd2, 32'h0, r, lat, e, e1, cec, mv);
        chk("ws_lat", lat, 32'd5);
        chk("ws_ce_cycles", cec, 32'd4);
        chk("ws_addr_stable", {31'd0, mv}, 32'd0);
        chk("ws_data", r, 32'hDEAD_BEEF);
        sram_wait = 0;

        // Misaligned word read and an SRAM ERROR response
        op("mis_word", 0, 32'h102, 3'd2, 32'h0, r);
        err_req++;
        xfer(0, 32'h104, 3'd2, 32'h0, r, lat, e, e1, cec, mv);
        chk("serr_lat", lat, 32'd3);
        chk("serr_resp", {31'd0, e}, 32'd1);
        chk("serr_err1", {31'd0, e1}, 32'd1);
        chk("serr_ce_once", cec, 32'd1);
`ifndef AHB_SRAM_BRIDGE_WBUF_EN
        chk("wbuf_err_tied", {31'd0, bus.WBUF_ERR}, 32'd0);
`endif

        // Upper address bits are stripped
        op("hi_wr", 1, 32'h8000_0108, 3'd2, $urandom, r);
        op("hi_rd", 0, 32'hFFC0_0108, 3'd2, 32'h0, r);

        // Reset while the SRAM holds READY low
        sram_wait = 20;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h4;
        bus.HWRITE = 1'b0; bus.HSIZE = 3'd2;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        @(negedge HCLK);
        chk("rst_pre_ce", {31'd0, bus.TB_CE}, 32'd1);
        #2 HRESETn = 1'b0;
        #1 check_reset("midrst");
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        sram_wait = 0;
        op("post_rst_rd", 0, 32'h0, 3'd2, 32'h0, r);

        // Randomized transfers in a small window
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = 32'h300 + 32'($urandom_range(0, 31));
            sram_wait = $urandom_range(0, 2);
            op("rnd", wr, a, sz, $urandom, r);
        end
        sram_wait = 0;

`ifdef AHB_SRAM_BRIDGE_WBUF_EN
        // Posted write followed by a read of the same word
        xfer(1, 32'h200, 3'd2, 32'h11, r, lat, e, e1, cec, mv);
        chk("wb_wr_lat", lat, 32'd1);
        chk("wb_wr_resp", {31'd0, e}, 32'd0);
        ref_write(32'h200, 3'd2, 32'h11);
        xfer(0, 32'h200, 3'd2, 32'h0, r, lat, e, e1, cec, mv);
        chk("wb_rd_data", r, 32'h11);
        chk("wb_rd_stall", {31'd0, (lat > 2)}, 32'd1);
        // SRAM ERROR on a drained write is flagged, not reported on AHB
        err_req++;
        xfer(1, 32'h204, 3'd2, 32'h55, r, lat, e, e1, cec, mv);
        chk("wb_err_wlat", lat, 32'd1);
        chk("wb_err_resp", {31'd0, e}, 32'd0);
        repeat (6) @(posedge HCLK);
        #1;
        chk("wb_err_flag", {31'd0, bus.WBUF_ERR}, 32'd1);
        chk("wb_err_hresp", {31'd0, bus.HRESP}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
